// File: rtl/score_bcd_counter.sv
`timescale 1ns/1ps
// Four-digit BCD score counter with debounced increment/clear buttons and a
// synchronous increment input; saturates at 9999 with a sticky overflow flag.
module score_bcd_counter #(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = CLK_FREQ / 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_inc,
  input  logic        btn_clr,
  input  logic        inc_pulse,
  output logic [15:0] value,
  output logic        overflow
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned NUM_BTN = 2;
  localparam int unsigned BTN_INC = 0;
  localparam int unsigned BTN_CLR = 1;
  localparam int unsigned DIGITS  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] VALUE_MAX = 16'h9999;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press_c;
  logic               inc_evt_c;
  logic               clr_evt_c;
  logic [15:0]        value_inc_c;
  logic               carry;

  assign btn_raw = {btn_clr, btn_inc};

  // Per-button synchronizer, debounce counter and rising-edge press detector.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        stable   <= 1'b0;
        stable_q <= 1'b0;
        cnt      <= '0;
      end else begin
        s1       <= btn_raw[i];
        s2       <= s1;
        stable_q <= stable;
        if (s2 == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign press_c[i] = stable & ~stable_q;
  end

  // A button press and inc_pulse in the same cycle merge into one increment.
  assign inc_evt_c = inc_pulse | press_c[BTN_INC];
  assign clr_evt_c = press_c[BTN_CLR];

  // Ripple BCD +1: each digit 9 wraps to 0 and carries upward.
  always_comb begin
    value_inc_c = value;
    carry       = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (value[4*d +: 4] == 4'd9) begin
          value_inc_c[4*d +: 4] = 4'd0;
        end else begin
          value_inc_c[4*d +: 4] = value[4*d +: 4] + 4'd1;
          carry                 = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value    <= 16'h0000;
      overflow <= 1'b0;
    end else if (clr_evt_c) begin
      value    <= 16'h0000;
      overflow <= 1'b0;
    end else if (inc_evt_c && !overflow) begin
      if (value == VALUE_MAX) begin
        overflow <= 1'b1;
      end else begin
        value <= value_inc_c;
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_counter.sv
`timescale 1ns/1ps
// Scoreboard bench for score_bcd_counter with DEBOUNCE_CYCLES = 4.
module tb_score_bcd_counter;

  localparam int unsigned DC = 4;
  localparam int PRESS_EDGE  = DC + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_inc;
  logic        btn_clr;
  logic        inc_pulse;
  logic [15:0] value;
  logic        overflow;

  typedef struct packed {
    logic [15:0] v;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   model_cnt = 0;
  logic model_ovf = 1'b0;

  score_bcd_counter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_inc   (btn_inc),
    .btn_clr   (btn_clr),
    .inc_pulse (inc_pulse),
    .value     (value),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic void model_inc();
    if (!model_ovf) begin
      if (model_cnt == 9999) model_ovf = 1'b1;
      else model_cnt++;
    end
  endfunction

  function automatic void model_clr();
    model_cnt = 0;
    model_ovf = 1'b0;
  endfunction

  function automatic exp_t model_now();
    return {to_bcd(model_cnt), model_ovf};
  endfunction

  // Stimulus only: inc_pulse held for n consecutive edges.
  task automatic pulse_burst(input int n);
    inc_pulse = 1'b1;
    repeat (n) begin
      model_inc();
      @(negedge clk);
    end
    inc_pulse = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; btn_inc = 1'b0; btn_clr = 1'b0; inc_pulse = 1'b0;
    model_clr();
    exp_q.push_back(model_now());
    #12;
    e = exp_q.pop_front();
    n_checks++;
    if ({value, overflow} !== e) begin
      n_fail++;
      $display("FAIL reset_hold: got value=%h ovf=%b, want value=%h ovf=%b", value, overflow, e.v, e.o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      exp_q.push_back(model_now());
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({value, overflow} !== e) begin
        n_fail++;
        $display("FAIL reset_release: got value=%h ovf=%b, want value=%h ovf=%b", value, overflow, e.v, e.o);
      end
    end
  endtask

  task automatic test_pulse_isolated();
    exp_t e;
    for (int k = 0; k < 24; k++) begin
      inc_pulse = (k % 2 == 0);
      if (inc_pulse) model_inc();
      exp_q.push_back(model_now());
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({value, overflow} !== e) begin
        n_fail++;
        $display("FAIL pulse_isolated[%0d]: got value=%h ovf=%b, want value=%h ovf=%b", k, value, overflow, e.v, e.o);
      end
    end
    inc_pulse = 1'b0;
    exp_q.push_back({16'h0012, 1'b0});
    e = exp_q.pop_front();
    n_checks++;
    if ({value, overflow} !== e) begin
      n_fail++;
      $display("FAIL pulse_twelve: got value=%h, want value=%h", value, e.v);
    end
  endtask

  task automatic test_carry();
    exp_t e;
    int   targets[2] = '{99, 999};
    logic [15:0] after[2] = '{16'h0100, 16'h1000};
    for (int t = 0; t < 2; t++) begin
      pulse_burst(targets[t] - model_cnt);
      inc_pulse = 1'b1;
      model_inc();
      exp_q.push_back({after[t], 1'b0});
      @(negedge clk);
      inc_pulse = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if ({value, overflow} !== e) begin
        n_fail++;
        $display("FAIL carry_%0d: got value=%h ovf=%b, want value=%h ovf=%b", targets[t], value, overflow, e.v, e.o);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    pulse_burst(9998 - model_cnt);
    for (int k = 0; k < 3; k++) begin
      inc_pulse = 1'b1;
      model_inc();
      exp_q.push_back(model_now());
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({value, overflow} !== e) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got value=%h ovf=%b, want value=%h ovf=%b", k, value, overflow, e.v, e.o);
      end
    end
    inc_pulse = 1'b0;
    // btn_clr held 10 edges, then released; clear lands on edge DC+3.
    for (int k = 1; k <= 20; k++) begin
      btn_clr = (k <= 10);
      if (k == PRESS_EDGE) model_clr();
      exp_q.push_back(model_now());
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({value, overflow} !== e) begin
        n_fail++;
        $display("FAIL btn_clear[edge %0d]: got value=%h ovf=%b, want value=%h ovf=%b", k, value, overflow, e.v, e.o);
      end
    end
    btn_clr = 1'b0;
  endtask

  task automatic test_btn_debounce();
    exp_t e;
    pulse_burst(3);
    for (int k = 1; k <= 12; k++) begin
      btn_inc = (k <= 3);
      exp_q.push_back(model_now());
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({value, overflow} !== e) begin
        n_fail++;
        $display("FAIL btn_glitch[edge %0d]: got value=%h, want value=%h", k, value, e.v);
      end
    end
    for (int k = 1; k <= 32; k++) begin
      btn_inc = (k <= 20);
      if (k == PRESS_EDGE) model_inc();
      exp_q.push_back(model_now());
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({value, overflow} !== e) begin
        n_fail++;
        $display("FAIL btn_press[edge %0d]: got value=%h, want value=%h", k, value, e.v);
      end
    end
    btn_inc = 1'b0;
  endtask

  task automatic test_same_cycle();
    exp_t e;
    pulse_burst(5 - model_cnt);
    // Clear press coincides with inc_pulse: clear wins.
    for (int k = 1; k <= 20; k++) begin
      btn_clr   = (k <= 10);
      inc_pulse = (k == PRESS_EDGE);
      if (k == PRESS_EDGE) model_clr();
      exp_q.push_back(model_now());
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({value, overflow} !== e) begin
        n_fail++;
        $display("FAIL clr_vs_inc[edge %0d]: got value=%h ovf=%b, want value=%h ovf=%b", k, value, overflow, e.v, e.o);
      end
    end
    // Increment press coincides with inc_pulse: single +1.
    for (int k = 1; k <= 20; k++) begin
      btn_clr   = 1'b0;
      btn_inc   = (k <= 10);
      inc_pulse = (k == PRESS_EDGE);
      if (k == PRESS_EDGE) model_inc();
      exp_q.push_back(model_now());
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({value, overflow} !== e) begin
        n_fail++;
        $display("FAIL inc_merge[edge %0d]: got value=%h, want value=%h", k, value, e.v);
      end
    end
    btn_inc   = 1'b0;
    inc_pulse = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    pulse_burst(42 - model_cnt);
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_clr();
    exp_q.push_back(model_now());
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if ({value, overflow} !== e) begin
      n_fail++;
      $display("FAIL reset_async: got value=%h ovf=%b, want value=%h ovf=%b", value, overflow, e.v, e.o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Button held through reset is re-qualified from scratch.
    for (int k = 1; k <= 20; k++) begin
      btn_inc = (k <= 10);
      if (k == PRESS_EDGE) model_inc();
      exp_q.push_back(model_now());
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({value, overflow} !== e) begin
        n_fail++;
        $display("FAIL reset_requal[edge %0d]: got value=%h, want value=%h", k, value, e.v);
      end
    end
    btn_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pulse_isolated();
    test_carry();
    test_saturate();
    test_btn_debounce();
    test_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
